// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 MEM stage; one data-memory access per instruction, load formatting, writeback bundle.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses trap (wb_exc) instead of being aligned down.
module mem_access_stage #(
    parameter int XLEN        = 64,
    parameter int REG_W       = 6,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_busy,
    input  logic [XLEN-1:0]        in_result,
    input  logic [XLEN-1:0]        in_store_data,
    input  logic [REG_W-1:0]       in_dest_reg,
    input  logic                   in_mem_active,
    input  logic                   in_load,
    input  logic [1:0]             in_size,
    input  logic                   in_unsigned,
    output logic                   dmem_req_valid,
    input  logic                   dmem_req_ready,
    output logic [XLEN-1:0]        dmem_req_addr,
    output logic                   dmem_req_we,
    output logic [XLEN-1:0]        dmem_req_wdata,
    output logic [7:0]             dmem_req_wstrb,
    input  logic                   dmem_resp_valid,
    input  logic [XLEN-1:0]        dmem_resp_rdata,
    output logic                   wb_valid,
    output logic                   wb_wr_en,
    output logic [REG_W-1:0]       wb_dest_reg,
    output logic [XLEN-1:0]        wb_data,
    output logic                   wb_exc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t r_state, w_next;
    logic [XLEN-1:0] r_addr, r_wdata, r_wb_data;
    logic [7:0] r_wstrb;
    logic r_we, r_unsigned, r_wb_valid, r_wb_wr_en, r_wb_exc;
    logic [1:0] r_size;
    logic [2:0] r_lane;
    logic [REG_W-1:0] r_dest, r_wb_dest;
    logic [STALL_CNT_W-1:0] r_stall;
    logic w_accept, w_misalign;
    logic [2:0] w_low, w_lane;
    logic [7:0] w_strb_base;
    logic [XLEN-1:0] w_shift, w_load_data;

    assign in_busy        = r_state != IDLE;
    assign w_accept       = in_valid && !in_busy;
    assign w_low          = (3'b001 << in_size) - 3'b001;
    assign w_lane         = in_result[2:0] & ~w_low;
    assign w_strb_base    = in_size == 2'd0 ? 8'h01 : in_size == 2'd1 ? 8'h03 : in_size == 2'd2 ? 8'h0F : 8'hFF;
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign     = (in_result[2:0] & w_low) != 3'b000;
`else
    assign w_misalign     = 1'b0;
`endif
    assign w_shift        = dmem_resp_rdata >> {r_lane, 3'b000};
    assign w_load_data    = r_size == 2'd0 ? {{(XLEN-8){!r_unsigned & w_shift[7]}}, w_shift[7:0]} :
                            r_size == 2'd1 ? {{(XLEN-16){!r_unsigned & w_shift[15]}}, w_shift[15:0]} :
                            r_size == 2'd2 ? {{(XLEN-32){!r_unsigned & w_shift[31]}}, w_shift[31:0]} : w_shift;
    assign dmem_req_valid = r_state == REQ;
    assign dmem_req_addr  = r_addr;
    assign dmem_req_we    = r_we;
    assign dmem_req_wdata = r_wdata;
    assign dmem_req_wstrb = r_wstrb;
    assign wb_valid       = r_wb_valid;
    assign wb_wr_en       = r_wb_wr_en;
    assign wb_dest_reg    = r_wb_dest;
    assign wb_data        = r_wb_data;
    assign wb_exc         = r_wb_exc;
    assign stall_cycles   = r_stall;

    // State register; reset aborts any outstanding transaction.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: IDLE -> REQ on a memory op, REQ -> IDLE/WAIT on handshake, WAIT -> IDLE on response.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid && in_mem_active && !w_misalign) w_next = REQ;
            REQ:     if (dmem_req_ready) w_next = r_we ? IDLE : WAIT;
            WAIT:    if (dmem_resp_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bundle capture, writeback bundle generation and stall counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_we       <= 1'b0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_lane     <= '0;
            r_dest     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_wr_en <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (in_busy) r_stall <= r_stall + STALL_CNT_W'(1);
            if (w_accept && (!in_mem_active || w_misalign)) begin
                r_wb_valid <= 1'b1;
                r_wb_wr_en <= !in_mem_active && in_dest_reg != '0;
                r_wb_dest  <= in_dest_reg;
                r_wb_data  <= in_result;
                r_wb_exc   <= w_misalign && in_mem_active;
            end else if (w_accept) begin
                r_addr     <= {in_result[XLEN-1:3], 3'b000};
                r_wdata    <= in_store_data << {w_lane, 3'b000};
                r_wstrb    <= w_strb_base << w_lane;
                r_we       <= !in_load;
                r_size     <= in_size;
                r_unsigned <= in_unsigned;
                r_lane     <= w_lane;
                r_dest     <= in_dest_reg;
            end
            if (r_state == REQ && dmem_req_ready && r_we) begin
                r_wb_valid <= 1'b1;
                r_wb_wr_en <= 1'b0;
                r_wb_dest  <= r_dest;
                r_wb_exc   <= 1'b0;
            end
            if (r_state == WAIT && dmem_resp_valid) begin
                r_wb_valid <= 1'b1;
                r_wb_wr_en <= r_dest != '0;
                r_wb_dest  <= r_dest;
                r_wb_data  <= w_load_data;
                r_wb_exc   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage (honours MEM_MISALIGN_TRAP_EN when defined).
module tb_mem_access_stage;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_busy, in_mem_active = 1'b0, in_load = 1'b0, in_unsigned = 1'b0;
    logic [63:0] in_result = '0, in_store_data = '0;
    logic [5:0] in_dest_reg = '0;
    logic [1:0] in_size = '0;
    logic dmem_req_valid, dmem_req_ready = 1'b0, dmem_req_we, dmem_resp_valid = 1'b0;
    logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata = '0, wb_data;
    logic [7:0] dmem_req_wstrb;
    logic wb_valid, wb_wr_en, wb_exc;
    logic [5:0] wb_dest_reg;
    logic [31:0] stall_cycles, stall_before;

    typedef struct {
        logic [5:0]  dest;
        logic [63:0] data;
        logic        wr;
        logic        exc;
        logic        cd;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_pass = 0;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_busy(in_busy),
        .in_result(in_result), .in_store_data(in_store_data), .in_dest_reg(in_dest_reg),
        .in_mem_active(in_mem_active), .in_load(in_load), .in_size(in_size), .in_unsigned(in_unsigned),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
        .dmem_req_we(dmem_req_we), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_dest_reg(wb_dest_reg), .wb_data(wb_data),
        .wb_exc(wb_exc), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Pop one expected writeback per wb_valid pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) chk("wb_unexpected", wb_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("wb_dest", wb_dest_reg, e.dest);
                chk("wb_wr_en", wb_wr_en, e.wr);
                chk("wb_exc", wb_exc, e.exc);
                if (e.cd) chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic mem(input logic [63:0] a, input logic [1:0] sz, input logic uns, input logic ld,
                       input logic [63:0] sd, input logic [5:0] d, input int rdly, input logic [63:0] rd,
                       input logic [63:0] ea, input logic [7:0] es, input logic [63:0] ew, input logic [63:0] ed);
        in_valid = 1'b1; in_mem_active = 1'b1; in_result = a; in_size = sz; in_unsigned = uns;
        in_load = ld; in_store_data = sd; in_dest_reg = d;
        sb.push_back('{dest: d, data: ed, wr: ld && d != 6'd0, exc: 1'b0, cd: ld});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("req_valid", dmem_req_valid, 1'b1);
        chk("req_addr", dmem_req_addr, ea);
        chk("req_we", dmem_req_we, !ld);
        if (!ld) begin
            chk("req_wstrb", dmem_req_wstrb, es);
            chk("req_wdata", dmem_req_wdata, ew);
        end
        repeat (rdly) begin
            @(posedge clk); #1;
            chk("hold_valid", dmem_req_valid, 1'b1);
            chk("hold_addr", dmem_req_addr, ea);
            if (!ld) chk("hold_wdata", dmem_req_wdata, ew);
        end
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        if (ld) begin
            chk("wait_busy", in_busy, 1'b1);
            dmem_resp_valid = 1'b1; dmem_resp_rdata = rd;
            @(posedge clk); #1;
            dmem_resp_valid = 1'b0;
        end
        chk("idle_busy", in_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        dmem_resp_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        chk("rst_busy", in_busy, 1'b0);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_req_addr", dmem_req_addr, 64'h0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 64'h0);
        chk("rst_stall", stall_cycles, 32'h0);

        in_valid = 1'b1; in_mem_active = 1'b0; in_result = 64'h1234; in_dest_reg = 6'd5;
        repeat (3) begin
            sb.push_back('{dest: 6'd5, data: 64'h1234, wr: 1'b1, exc: 1'b0, cd: 1'b1});
            @(posedge clk); #1;
            chk("alu_busy", in_busy, 1'b0);
        end
        in_result = 64'h0BAD; in_dest_reg = 6'd0;
        sb.push_back('{dest: 6'd0, data: 64'h0BAD, wr: 1'b0, exc: 1'b0, cd: 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("alu_stall", stall_cycles, 32'h0);

        mem(64'h1003, 2'd0, 1'b0, 1'b1, 64'h0, 6'd3, 0, 64'h00000000_80000000, 64'h1000, 8'h0, 64'h0, 64'hFFFFFFFF_FFFFFF80);
        mem(64'h1003, 2'd0, 1'b1, 1'b1, 64'h0, 6'd3, 1, 64'h00000000_80000000, 64'h1000, 8'h0, 64'h0, 64'h80);
        mem(64'h4006, 2'd1, 1'b1, 1'b1, 64'h0, 6'd9, 0, 64'hBEEF0000_00000000, 64'h4000, 8'h0, 64'h0, 64'hBEEF);
        mem(64'h4006, 2'd1, 1'b0, 1'b1, 64'h0, 6'd9, 0, 64'hBEEF0000_00000000, 64'h4000, 8'h0, 64'h0, 64'hFFFFFFFF_FFFFBEEF);
        mem(64'h5004, 2'd2, 1'b1, 1'b1, 64'h0, 6'd10, 0, 64'h87654321_00000000, 64'h5000, 8'h0, 64'h0, 64'h87654321);
        mem(64'h0, 2'd3, 1'b0, 1'b1, 64'h0, 6'd0, 0, 64'hFFFF, 64'h0, 8'h0, 64'h0, 64'hFFFF);

        stall_before = stall_cycles;
        mem(64'h2004, 2'd2, 1'b0, 1'b0, 64'hDEADBEEF, 6'd4, 3, 64'h0, 64'h2000, 8'hF0, 64'hDEADBEEF_00000000, 64'h0);
        chk("store_stall", stall_cycles - stall_before, 32'd4);
        mem(64'h010A, 2'd1, 1'b0, 1'b0, 64'h12345678, 6'd6, 0, 64'h0, 64'h0108, 8'h0C, 64'h00001234_56780000, 64'h0);
        mem(64'h0018, 2'd3, 1'b0, 1'b0, 64'h01234567_89ABCDEF, 6'd7, 0, 64'h0, 64'h0018, 8'hFF, 64'h01234567_89ABCDEF, 64'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        in_valid = 1'b1; in_mem_active = 1'b1; in_load = 1'b1; in_size = 2'd2; in_unsigned = 1'b0;
        in_result = 64'h3002; in_dest_reg = 6'd7;
        sb.push_back('{dest: 6'd7, data: 64'h3002, wr: 1'b0, exc: 1'b1, cd: 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("trap_req_valid", dmem_req_valid, 1'b0);
        chk("trap_busy", in_busy, 1'b0);
`else
        mem(64'h3002, 2'd2, 1'b0, 1'b1, 64'h0, 6'd7, 0, 64'h11111111_89ABCDEF, 64'h3000, 8'h0, 64'h0, 64'hFFFFFFFF_89ABCDEF);
        mem(64'h3006, 2'd2, 1'b0, 1'b0, 64'hCAFEF00D, 6'd8, 0, 64'h0, 64'h3000, 8'hF0, 64'hCAFEF00D_00000000, 64'h0);
`endif

        in_valid = 1'b1; in_mem_active = 1'b1; in_load = 1'b1; in_size = 2'd3; in_result = 64'h6000; in_dest_reg = 6'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        chk("rstw_busy_pre", in_busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstw_busy", in_busy, 1'b0);
        chk("rstw_req_valid", dmem_req_valid, 1'b0);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'h55;
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_busy_end", in_busy, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
